// File: rtl/kp_pkg.sv
// Shared types and sizing helpers for the kernel line feeder and its position counter.
// Build option: KP_LINE_FEEDER_FLUSH_EN adds the FLUSH state for the bottom-row drain line.
package kp_pkg;

   localparam int KP_FLUSH_VALUE_DEFAULT = 0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_REQ = 3'd1,
      ST_BURST    = 3'd2,
      ST_GAP      = 3'd3,
`ifdef KP_LINE_FEEDER_FLUSH_EN
      ST_FLUSH    = 3'd4,
`endif
      ST_DONE     = 3'd5
   } kp_feeder_state_t;

   // One spare bit so the counters can reach LINE_LENGTH/LINE_COUNT without wrapping.
   function automatic int kpPixelWidth(input int lineLength);
      return $clog2(lineLength) + 1;
   endfunction

   function automatic int kpLineWidth(input int lineCount);
      return $clog2(lineCount) + 1;
   endfunction

endpackage

// File: rtl/kp_pos_counter.sv
// Pixel/line position counter pair with end-of-line and end-of-frame flags.
// Pixel wraps to zero only on the explicit end-of-line compare; the line counter only clears on i_clear.
module kp_pos_counter
   import kp_pkg::*;
#(
   parameter int LINE_LENGTH = 640,
   parameter int LINE_COUNT  = 480,
   parameter int PW          = kpPixelWidth(LINE_LENGTH),
   parameter int LW          = kpLineWidth(LINE_COUNT)
)(
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_clear,
   input  logic          i_step,
   output logic [PW-1:0] o_pixel,
   output logic [LW-1:0] o_line,
   output logic          o_line_end,
   output logic          o_frame_end
);

   logic [PW-1:0] r_pixel;
   logic [LW-1:0] r_line;
   logic          w_lineEnd;

   assign w_lineEnd = (r_pixel == PW'(LINE_LENGTH - 1));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_pixel <= '0;
         r_line  <= '0;
      end else if (i_clear) begin
         r_pixel <= '0;
         r_line  <= '0;
      end else if (i_step) begin
         if (w_lineEnd) begin
            r_pixel <= '0;
            r_line  <= r_line + LW'(1);
         end else begin
            r_pixel <= r_pixel + PW'(1);
         end
      end
   end

   assign o_pixel     = r_pixel;
   assign o_line      = r_line;
   assign o_line_end  = w_lineEnd;
   // Frame end means every image line has been consumed, not that the last pixel is in flight.
   assign o_frame_end = (r_line == LW'(LINE_COUNT));

endmodule

// File: rtl/kp_line_feeder.sv
// Line-granular pixel sequencer: pops one whole line from the pixel FIFO per line request.
// Build option: KP_LINE_FEEDER_FLUSH_EN appends a constant FLUSH_VALUE line after the last image row.
module kp_line_feeder
   import kp_pkg::*;
#(
   parameter int LINE_LENGTH = 640,
   parameter int LINE_COUNT  = 480,
   parameter int DATA_WIDTH  = 8
`ifdef KP_LINE_FEEDER_FLUSH_EN
   ,
   parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = DATA_WIDTH'(KP_FLUSH_VALUE_DEFAULT)
`endif
)(
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_rd,
   input  logic                  i_req,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_sof,
   output logic                  o_eol,
   output logic                  o_eof,
   output logic                  o_busy,
   output logic                  o_underflow
);

   localparam int PW = kpPixelWidth(LINE_LENGTH);
   localparam int LW = kpLineWidth(LINE_COUNT);

   kp_feeder_state_t      r_state;
   kp_feeder_state_t      w_nextState;

   logic [PW-1:0]         w_pixel;
   logic [LW-1:0]         w_line;
   logic                  w_lineEnd;
   logic                  w_frameEnd;
   logic                  w_clear;
   logic                  w_step;
   logic                  w_pop;
   logic                  w_flushEmit;
   logic                  w_firstPixel;

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_sof;
   logic                  r_eol;
   logic                  r_eof;
   logic                  r_underflow;

   kp_pos_counter #(
      .LINE_LENGTH (LINE_LENGTH),
      .LINE_COUNT  (LINE_COUNT),
      .PW          (PW),
      .LW          (LW)
   ) u_pos (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_clear     (w_clear),
      .i_step      (w_step),
      .o_pixel     (w_pixel),
      .o_line      (w_line),
      .o_line_end  (w_lineEnd),
      .o_frame_end (w_frameEnd)
   );

   assign w_clear      = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_step       = w_pop || w_flushEmit;
   assign w_firstPixel = (w_pixel == '0) && (w_line == '0);

`ifdef KP_LINE_FEEDER_FLUSH_EN
   logic r_flushRun;

   // The flush line waits for one request, then streams out back-to-back like a normal burst.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_flushRun <= 1'b0;
      end else if (r_state != ST_FLUSH) begin
         r_flushRun <= 1'b0;
      end else if (i_req) begin
         r_flushRun <= 1'b1;
      end
   end

   assign w_flushEmit = (r_state == ST_FLUSH) && r_flushRun;
`else
   logic w_lastImagePixel;

   assign w_flushEmit      = 1'b0;
   assign w_lastImagePixel = w_lineEnd && (w_line == LW'(LINE_COUNT - 1));
`endif

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_enable) begin
               w_nextState = ST_WAIT_REQ;
            end
         end
         ST_WAIT_REQ: begin
            if (w_frameEnd) begin
`ifdef KP_LINE_FEEDER_FLUSH_EN
               w_nextState = ST_FLUSH;
`else
               w_nextState = ST_DONE;
`endif
            end else if (i_req) begin
               w_nextState = ST_BURST;
            end
         end
         // A started line always completes: an empty FIFO only stalls the burst.
         ST_BURST: begin
            w_pop = !i_fifo_empty;
            if (w_pop && w_lineEnd) begin
               w_nextState = ST_GAP;
            end
         end
         ST_GAP: begin
            w_nextState = ST_WAIT_REQ;
         end
`ifdef KP_LINE_FEEDER_FLUSH_EN
         ST_FLUSH: begin
            if (w_flushEmit && w_lineEnd) begin
               w_nextState = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            w_nextState = i_enable ? ST_WAIT_REQ : ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_eof   <= 1'b0;
      end else begin
         r_valid <= w_step;
         r_sof   <= 1'b0;
         r_eol   <= 1'b0;
         r_eof   <= 1'b0;
         if (w_pop) begin
            r_data <= i_fifo_data;
            r_sof  <= w_firstPixel;
            r_eol  <= w_lineEnd;
`ifdef KP_LINE_FEEDER_FLUSH_EN
            r_eof  <= 1'b0;
`else
            r_eof  <= w_lastImagePixel;
`endif
         end
`ifdef KP_LINE_FEEDER_FLUSH_EN
         else if (w_flushEmit) begin
            r_data <= FLUSH_VALUE;
            r_eol  <= w_lineEnd;
            r_eof  <= w_lineEnd;
         end
`endif
      end
   end

   // Sticky underflow is re-armed as the first line of each frame starts its burst.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_underflow <= 1'b0;
      end else if ((r_state == ST_WAIT_REQ) && (w_nextState == ST_BURST) && (w_line == '0)) begin
         r_underflow <= 1'b0;
      end else if ((r_state == ST_BURST) && i_fifo_empty) begin
         r_underflow <= 1'b1;
      end
   end

   assign o_fifo_rd   = w_pop;
   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_sof       = r_sof;
   assign o_eol       = r_eol;
   assign o_eof       = r_eof;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_underflow = r_underflow;

endmodule

// File: tb/tb_kp_line_feeder.sv
// Scoreboard bench for kp_line_feeder on a 4x3 frame; expectations follow KP_LINE_FEEDER_FLUSH_EN.
module tb_kp_line_feeder;

   localparam int LL           = 4;
   localparam int LC           = 3;
   localparam int DW           = 8;
   localparam int FRAME_PIXELS = LL * LC;
`ifdef KP_LINE_FEEDER_FLUSH_EN
   localparam bit FLUSH_ON     = 1'b1;
`else
   localparam bit FLUSH_ON     = 1'b0;
`endif
   localparam logic [DW-1:0] FLUSH_PIX = 8'hA5;

   logic          i_clk = 1'b0;
   logic          i_rstn;
   logic          i_enable;
   logic [DW-1:0] i_fifo_data;
   logic          i_fifo_empty;
   logic          o_fifo_rd;
   logic          i_req;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_sof;
   logic          o_eol;
   logic          o_eof;
   logic          o_busy;
   logic          o_underflow;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sof;
      logic          eol;
      logic          eof;
   } expPixel_t;

   expPixel_t     sbQueue[$];
   logic [DW-1:0] fifoMem [0:255];
   logic [7:0]    wrPtr = 8'd0;
   logic [7:0]    rdPtr = 8'd0;
   logic          forceEmpty = 1'b0;
   logic [DW-1:0] nextPixel = 8'h10;
   int            popCount = 0;
   int            cycleCount = 0;
   int            validCount = 0;
   int            validAt [0:255];
   int            checks = 0;
   int            errors = 0;
   int            p0;
   int            base;

   always #5 i_clk = ~i_clk;

   kp_line_feeder #(
      .LINE_LENGTH  (LL),
      .LINE_COUNT   (LC),
      .DATA_WIDTH   (DW)
`ifdef KP_LINE_FEEDER_FLUSH_EN
      ,
      .FLUSH_VALUE  (FLUSH_PIX)
`endif
   ) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_enable     (i_enable),
      .i_fifo_data  (i_fifo_data),
      .i_fifo_empty (i_fifo_empty),
      .o_fifo_rd    (o_fifo_rd),
      .i_req        (i_req),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_sof        (o_sof),
      .o_eol        (o_eol),
      .o_eof        (o_eof),
      .o_busy       (o_busy),
      .o_underflow  (o_underflow)
   );

   // First-word-fall-through FIFO model; the read pointer moves on the DUT's pop.
   assign i_fifo_data  = fifoMem[rdPtr];
   assign i_fifo_empty = (rdPtr == wrPtr) || forceEmpty;

   always @(posedge i_clk) begin
      if (o_fifo_rd) begin
         rdPtr    <= rdPtr + 8'd1;
         popCount <= popCount + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Output monitor: every valid pixel is matched against the head of the scoreboard.
   always @(negedge i_clk) begin
      expPixel_t e;
      cycleCount++;
      if (o_valid) begin
         validAt[validCount % 256] = cycleCount;
         validCount++;
         if (sbQueue.size() == 0) begin
            checkOutput("unexpectedPixel", 32'd1, 32'd0);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("pixel", {21'd0, o_data, o_sof, o_eol, o_eof}, {21'd0, e});
         end
      end else begin
         checkOutput("idleMarkers", {29'd0, o_sof, o_eol, o_eof}, 32'd0);
      end
   end

   task automatic loadPixels(input int n);
      for (int i = 0; i < n; i++) begin
         fifoMem[wrPtr] = nextPixel;
         wrPtr          = wrPtr + 8'd1;
         nextPixel      = nextPixel + 8'd1;
      end
   endtask

   task automatic pushFrame(input logic [7:0] startAddr);
      expPixel_t  e;
      logic [7:0] addr;
      for (int i = 0; i < FRAME_PIXELS; i++) begin
         addr  = startAddr + 8'(i);
         e.data = fifoMem[addr];
         e.sof  = (i == 0);
         e.eol  = ((i % LL) == LL - 1);
         e.eof  = !FLUSH_ON && (i == FRAME_PIXELS - 1);
         sbQueue.push_back(e);
      end
      if (FLUSH_ON) begin
         for (int i = 0; i < LL; i++) begin
            e.data = FLUSH_PIX;
            e.sof  = 1'b0;
            e.eol  = (i == LL - 1);
            e.eof  = (i == LL - 1);
            sbQueue.push_back(e);
         end
      end
   endtask

   task automatic applyStimulus(input int nFrames);
      for (int f = 0; f < nFrames; f++) begin
         for (int i = 0; i < FRAME_PIXELS; i++) begin
            fifoMem[wrPtr + 8'(i)] = nextPixel + 8'(i);
         end
         pushFrame(wrPtr);
         loadPixels(FRAME_PIXELS);
      end
      i_enable = 1'b1;
      @(negedge i_clk);
      checkOutput("busyStart", {31'd0, o_busy}, 32'd1);
   endtask

   task automatic waitPops(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (popCount >= target) break;
      end
      checkOutput("popWait", popCount, target);
   endtask

   task automatic waitIdle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (!o_busy) break;
      end
      checkOutput("idleReached", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rstn   = 1'b0;
      i_enable = 1'b0;
      i_req    = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("resetOutputs",
                  {17'd0, o_fifo_rd, o_valid, o_sof, o_eol, o_eof, o_busy, o_underflow, o_data}, 32'd0);
      i_rstn = 1'b1;
      @(negedge i_clk);
      checkOutput("idleAfterReset", {30'd0, o_busy, o_fifo_rd}, 32'd0);

      // Basic frame with the request held high: line spacing and marker placement.
      i_req = 1'b1;
      base  = validCount;
      p0    = popCount;
      applyStimulus(1);
      i_enable = 1'b0;
      waitIdle(200);
      checkOutput("frame1Pops", popCount - p0, FRAME_PIXELS);
      checkOutput("frame1Underflow", {31'd0, o_underflow}, 32'd0);
      checkOutput("lineSpan", validAt[(base + 3) % 256] - validAt[base % 256], 32'd3);
      checkOutput("gapLine01", validAt[(base + 4) % 256] - validAt[(base + 3) % 256], 32'd3);
      checkOutput("gapLine12", validAt[(base + 8) % 256] - validAt[(base + 7) % 256], 32'd3);

      // Two frames back to back; enable drops only during the second one.
      p0 = popCount;
      applyStimulus(2);
      waitPops(p0 + FRAME_PIXELS + 1, 300);
      i_enable = 1'b0;
      waitIdle(300);
      checkOutput("b2bPops", popCount - p0, 2 * FRAME_PIXELS);

      // FIFO runs dry for three cycles after pixel 1 of line 0.
      p0   = popCount;
      base = validCount;
      applyStimulus(1);
      i_enable = 1'b0;
      waitPops(p0 + 2, 50);
      forceEmpty = 1'b1;
      repeat (3) @(negedge i_clk);
      forceEmpty = 1'b0;
      checkOutput("underflowSet", {31'd0, o_underflow}, 32'd1);
      waitIdle(200);
      checkOutput("underflowSticky", {31'd0, o_underflow}, 32'd1);
      checkOutput("stallGap", validAt[(base + 2) % 256] - validAt[(base + 1) % 256], 32'd4);
      checkOutput("stallPops", popCount - p0, FRAME_PIXELS);

      // Request withheld after line 1 completes, then restored.
      p0 = popCount;
      applyStimulus(1);
      i_enable = 1'b0;
      waitPops(p0 + 1, 50);
      checkOutput("underflowClearedAtSof", {31'd0, o_underflow}, 32'd0);
      waitPops(p0 + 2 * LL, 50);
      i_req = 1'b0;
      repeat (10) @(negedge i_clk);
      checkOutput("holdPops", popCount - p0, 2 * LL);
      checkOutput("holdNoRead", {31'd0, o_fifo_rd}, 32'd0);
      checkOutput("holdBusy", {31'd0, o_busy}, 32'd1);
      i_req = 1'b1;
      @(negedge i_clk);
      checkOutput("resumeRead", {31'd0, o_fifo_rd}, 32'd1);
      waitIdle(200);
      checkOutput("holdFramePops", popCount - p0, FRAME_PIXELS);

      // Asynchronous reset between edges in the middle of a burst.
      p0 = popCount;
      applyStimulus(1);
      i_enable = 1'b0;
      waitPops(p0 + 2, 50);
      #2 i_rstn = 1'b0;
      #1;
      checkOutput("asyncReset",
                  {17'd0, o_fifo_rd, o_valid, o_sof, o_eol, o_eof, o_busy, o_underflow, o_data}, 32'd0);
      sbQueue.delete();
      loadPixels(FRAME_PIXELS - int'(wrPtr - rdPtr));
      pushFrame(rdPtr);
      @(negedge i_clk);
      i_rstn = 1'b1;
      p0     = popCount;
      i_enable = 1'b1;
      @(negedge i_clk);
      i_enable = 1'b0;
      waitIdle(200);
      checkOutput("restartPops", popCount - p0, FRAME_PIXELS);

      checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
